// File: rtl/lc3b_types.sv
// lc3b_types: shared types and constants for the LC-3b memory hierarchy.
//
// Contents used by the L2 write buffer:
//   lc3b_word, lc3b_cacheline  - address and cacheline payload types
//   lc3b_line_tag              - cacheline tag (address bits above the line offset)
//   LC3B_LINE_OFFSET_BITS      - byte-offset bits within a 16-byte line
//   lc3b_wbuf_state            - write buffer controller states
//   line_tag / line_base       - address <-> tag helpers
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [11:0]  lc3b_line_tag;

  localparam int LC3B_LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_L2,
    DRAIN,
    RESP
  } lc3b_wbuf_state;

  function automatic lc3b_line_tag line_tag(input lc3b_word addr);
    return addr[15:LC3B_LINE_OFFSET_BITS];
  endfunction

  // Line-aligned address for a tag; the offset bits are always zero.
  function automatic lc3b_word line_base(input lc3b_line_tag tag);
    return {tag, {LC3B_LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/wbuf_storage.sv
// wbuf_storage: circular FIFO of buffered cacheline writebacks.
//
// Holds DEPTH entries of {valid, tag, data} plus head/tail pointers and an
// occupancy count. Provides a tag lookup (at most one valid entry per tag).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   lookup_tag            tag of the current upstream request
//   write_data            data for push / coalesce
//   push                  append {lookup_tag, write_data} at the tail
//   coalesce              overwrite the matching entry's data in place
//   pop                   retire the head entry
//   hit                   some valid entry matches lookup_tag
//   hit_data              data of the matching entry (only with WBUF_READ_FWD_EN)
//   head_tag, head_data   oldest entry, the next one to drain
//   full, empty           occupancy flags
module wbuf_storage
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   lookup_tag,
  input  logic [127:0]  write_data,
  input  logic          push,
  input  logic          coalesce,
  input  logic          pop,
`ifdef WBUF_READ_FWD_EN
  output logic [127:0]  hit_data,
`endif
  output logic          hit,
  output logic [11:0]   head_tag,
  output logic [127:0]  head_data,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid;
  lc3b_line_tag     tags [DEPTH];
  lc3b_cacheline    data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] hit_idx;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] match_vec;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid[i] && (tags[i] == lookup_tag);
    end
  end

  // Tags are unique among valid entries, so a simple last-match scan is
  // enough to turn the match vector into an index.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) begin
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign hit       = |match_vec;
  assign head_tag  = tags[head];
  assign head_data = data[head];
  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
`ifdef WBUF_READ_FWD_EN
  assign hit_data  = data[hit_idx];
`endif

  // Payload array: no reset needed, the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail] <= lookup_tag;
      data[tail] <= write_data;
    end else if (coalesce) begin
      data[hit_idx] <= write_data;
    end
  end

  // Push and pop come from different controller states and never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: posted write buffer between the cache arbiter and L2.
//
// L1 writebacks are acknowledged once stored and drained to L2 whenever no
// upstream request is pending. Read misses pass through to L2; a read never
// overtakes a buffered write to the same line.
//
// Configuration macro: WBUF_READ_FWD_EN
//   defined   - read hits are answered from the buffer
//   undefined - a read hit drains the buffer until the line is gone, then
//               reads it from L2
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   up_address, up_wdata       upstream request address / writeback data
//   up_read, up_write          upstream request strobes, held until up_resp
//   up_resp, up_rdata          one-cycle completion pulse and read data
//   l2_address, l2_wdata       request to L2
//   l2_read, l2_write          L2 request strobes, held until l2_resp
//   l2_resp, l2_rdata          L2 completion pulse and read data
module l2_write_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   up_address,
  input  logic [127:0]  up_wdata,
  input  logic          up_read,
  input  logic          up_write,
  output logic          up_resp,
  output logic [127:0]  up_rdata,
  output logic [15:0]   l2_address,
  output logic [127:0]  l2_wdata,
  output logic          l2_read,
  output logic          l2_write,
  input  logic          l2_resp,
  input  logic [127:0]  l2_rdata
);

  lc3b_wbuf_state state;
  lc3b_wbuf_state idle_next;
  logic           hit;
  logic           full;
  logic           empty;
  logic           push;
  logic           coalesce;
  logic           pop;
  lc3b_line_tag   head_tag;
  lc3b_cacheline  head_data;
`ifdef WBUF_READ_FWD_EN
  lc3b_cacheline  hit_data;
`endif

  // The storage update happens on the IDLE->RESP edge, so no separate
  // WRITE cycle is spent.
  assign push     = (state == IDLE) && up_write && !hit && !full;
  assign coalesce = (state == IDLE) && up_write && hit;
  assign pop      = (state == DRAIN) && l2_resp;

  wbuf_storage #(.DEPTH(DEPTH)) storage (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (line_tag(up_address)),
    .write_data (up_wdata),
    .push       (push),
    .coalesce   (coalesce),
    .pop        (pop),
`ifdef WBUF_READ_FWD_EN
    .hit_data   (hit_data),
`endif
    .hit        (hit),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
  );

  // Decision taken in IDLE. Writes win over reads; a write that cannot be
  // stored forces a drain and stays pending until the next IDLE visit.
  always_comb begin
    idle_next = IDLE;
    if (up_write) begin
      idle_next = (hit || !full) ? RESP : DRAIN;
    end else if (up_read) begin
`ifdef WBUF_READ_FWD_EN
      idle_next = hit ? RESP : READ_L2;
`else
      idle_next = hit ? DRAIN : READ_L2;
`endif
    end else if (!empty) begin
      idle_next = DRAIN;
    end
  end

  // Controller and registered outputs. A drain, once started, only ends
  // on l2_resp (or reset).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      up_resp    <= 1'b0;
      up_rdata   <= '0;
      l2_address <= '0;
      l2_wdata   <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
    end else begin
      up_resp <= 1'b0;
      case (state)
        IDLE: begin
          state <= idle_next;
          case (idle_next)
            RESP: begin
              up_resp <= 1'b1;
`ifdef WBUF_READ_FWD_EN
              if (!up_write) begin
                up_rdata <= hit_data;
              end
`endif
            end
            READ_L2: begin
              l2_read    <= 1'b1;
              l2_address <= up_address;
            end
            DRAIN: begin
              l2_write   <= 1'b1;
              l2_address <= line_base(head_tag);
              l2_wdata   <= head_data;
            end
            default: ;
          endcase
        end
        READ_L2: begin
          if (l2_resp) begin
            l2_read  <= 1'b0;
            up_rdata <= l2_rdata;
            up_resp  <= 1'b1;
            state    <= RESP;
          end
        end
        DRAIN: begin
          if (l2_resp) begin
            l2_write <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
`timescale 1ns/1ps
module tb_l2_write_buffer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  up_address;
  logic [127:0] up_wdata;
  logic         up_read;
  logic         up_write;
  logic         up_resp;
  logic [127:0] up_rdata;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_read;
  logic         l2_write;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  l2_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .up_address (up_address),
    .up_wdata   (up_wdata),
    .up_read    (up_read),
    .up_write   (up_write),
    .up_resp    (up_resp),
    .up_rdata   (up_rdata),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_resp    (l2_resp),
    .l2_rdata   (l2_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: the buffer is an ordered list of lines (oldest first),
  // L2 is a sparse memory keyed by line tag.
  typedef struct {
    logic [11:0]  tag;
    logic [127:0] data;
  } entry_t;

  entry_t       buf_q[$];
  logic [127:0] l2mem [logic [11:0]];
  bit           op_is_read[$];

  int           checks = 0;
  int           failures = 0;
  int           l2_write_count = 0;
  int           l2_read_count = 0;
  int           resp_count = 0;
  int           last_resp_cyc = 0;
  int           last_read_resp_cyc = 0;
  logic [15:0]  last_l2_addr = '0;
  logic [127:0] last_l2_data = '0;
  logic [15:0]  cur_addr = '0;
  bit           l2_stall = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic int find_tag(input logic [11:0] t);
    foreach (buf_q[i]) begin
      if (buf_q[i].tag == t) return i;
    end
    return -1;
  endfunction

  function automatic logic [127:0] default_line(input logic [11:0] t);
    return {8{t, 4'h5}};
  endfunction

  function automatic logic [127:0] l2_line(input logic [11:0] t);
    if (l2mem.exists(t)) return l2mem[t];
    return default_line(t);
  endfunction

  // L2 side: checks every request against the model, answers after a
  // random latency (or while stalled, not at all), and abandons on reset.
  task automatic serve_l2();
    bit          is_write;
    logic [11:0] t;
    int          lat;
    is_write = l2_write;
    t = l2_address[15:4];
    if (is_write) begin
      checkOutput("drain_has_entry", 128'(buf_q.size() > 0), 128'(1));
      if (buf_q.size() > 0) begin
        checkOutput("drain_addr", 128'(l2_address), 128'({buf_q[0].tag, 4'h0}));
        checkOutput("drain_data", l2_wdata, buf_q[0].data);
      end
    end else begin
      checkOutput("read_addr", 128'(l2_address), 128'(cur_addr));
      checkOutput("read_no_bypass", 128'(find_tag(t) >= 0), 128'(0));
    end
    op_is_read.push_back(!is_write);
    lat = $urandom_range(0, 3);
    while ((l2_stall || lat > 0) && !reset) begin
      @(negedge clk);
      if (lat > 0) lat--;
    end
    if (reset) return;
    l2_resp = 1'b1;
    if (is_write) begin
      l2_write_count++;
      l2mem[t] = l2_wdata;
      last_l2_addr = l2_address;
      last_l2_data = l2_wdata;
      if (buf_q.size() > 0) void'(buf_q.pop_front());
    end else begin
      l2_read_count++;
      l2_rdata = l2_line(t);
      last_read_resp_cyc = cyc;
    end
    @(negedge clk);
    l2_resp = 1'b0;
    l2_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    l2_resp = 1'b0;
    l2_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && (l2_read || l2_write)) serve_l2();
    end
  end

  // Upstream side: issue one request, hold it until up_resp, then update
  // the model and check read data. lat counts negedges until up_resp.
  task automatic applyStimulus(input bit is_write, input logic [15:0] addr, input logic [127:0] data, output int lat);
    bit           got;
    logic [11:0]  t;
    int           idx;
    logic [127:0] exp_rd;
    t = addr[15:4];
    cur_addr = addr;
    up_address = addr;
    up_wdata = data;
    up_write = is_write;
    up_read = !is_write;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (up_resp) got = 1'b1;
    end
    up_read = 1'b0;
    up_write = 1'b0;
    checkOutput("resp_timeout", 128'(got), 128'(1));
    if (!got) return;
    resp_count++;
    last_resp_cyc = cyc;
    idx = find_tag(t);
    if (is_write) begin
      if (idx >= 0) begin
        buf_q[idx].data = data;
      end else begin
        checkOutput("accept_not_full", 128'(buf_q.size() < DEPTH), 128'(1));
        buf_q.push_back('{t, data});
      end
    end else begin
      exp_rd = (idx >= 0) ? buf_q[idx].data : l2_line(t);
      checkOutput("read_data", up_rdata, exp_rd);
    end
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((buf_q.size() != 0 || l2_write || l2_read || l2_resp) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 128'(buf_q.size()), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int           lat;
    int           wr;
    int           rd;
    int           rc;
    int           n_ops;
    int           n;
    logic [127:0] d0;
    logic [127:0] d1;
    logic [11:0]  t;

    reset = 1'b1;
    up_address = '0;
    up_wdata = '0;
    up_read = 1'b0;
    up_write = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_up_resp", 128'(up_resp), 128'(0));
    checkOutput("reset_up_rdata", up_rdata, 128'(0));
    checkOutput("reset_l2_address", 128'(l2_address), 128'(0));
    checkOutput("reset_l2_wdata", l2_wdata, 128'(0));
    checkOutput("reset_l2_read", 128'(l2_read), 128'(0));
    checkOutput("reset_l2_write", 128'(l2_write), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single write then drain");
    wr = l2_write_count;
    d0 = rand_line();
    applyStimulus(1'b1, 16'h1230, d0, lat);
    checkOutput("write_latency", 128'(lat), 128'(1));
    @(negedge clk);
    checkOutput("resp_one_cycle", 128'(up_resp), 128'(0));
    wait_drained();
    checkOutput("single_drain_count", 128'(l2_write_count - wr), 128'(1));
    checkOutput("single_drain_addr", 128'(last_l2_addr), 128'(16'h1230));
    checkOutput("single_drain_data", last_l2_data, d0);

    $display("[TB] coalescing two writes to one line");
    wr = l2_write_count;
    d0 = rand_line();
    d1 = rand_line();
    applyStimulus(1'b1, 16'h2000, d0, lat);
    applyStimulus(1'b1, 16'h2008, d1, lat);
    checkOutput("coalesce_latency", 128'(lat), 128'(2));
    wait_drained();
    checkOutput("coalesce_drain_count", 128'(l2_write_count - wr), 128'(1));
    checkOutput("coalesce_drain_addr", 128'(last_l2_addr), 128'(16'h2000));
    checkOutput("coalesce_drain_data", last_l2_data, d1);

    $display("[TB] write into a full buffer");
    wr = l2_write_count;
    l2_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'(i * 16), rand_line(), lat);
    end
    rc = resp_count;
    fork
      applyStimulus(1'b1, 16'h0040, rand_line(), lat);
      begin
        repeat (12) @(negedge clk);
        checkOutput("full_write_held", 128'(resp_count - rc), 128'(0));
        checkOutput("full_drain_started", 128'(l2_write), 128'(1));
        checkOutput("full_drain_head", 128'(l2_address), 128'(16'h0000));
        l2_stall = 1'b0;
      end
    join
    checkOutput("full_write_after_drain", 128'(lat > 12), 128'(1));
    wait_drained();
    checkOutput("full_total_drains", 128'(l2_write_count - wr), 128'(DEPTH + 1));

    $display("[TB] read of a buffered line");
    rd = l2_read_count;
    wr = l2_write_count;
    d0 = rand_line();
    applyStimulus(1'b1, 16'h4000, d0, lat);
    applyStimulus(1'b0, 16'h4004, '0, lat);
`ifdef WBUF_READ_FWD_EN
    checkOutput("hit_latency", 128'(lat), 128'(2));
    checkOutput("hit_no_l2_read", 128'(l2_read_count - rd), 128'(0));
`else
    checkOutput("hit_l2_read", 128'(l2_read_count - rd), 128'(1));
    checkOutput("hit_drained_first", 128'(l2_write_count - wr), 128'(1));
`endif
    checkOutput("hit_data", up_rdata, d0);
    wait_drained();

    $display("[TB] read miss ahead of pending drains");
    applyStimulus(1'b1, 16'h6000, rand_line(), lat);
    applyStimulus(1'b1, 16'h6010, rand_line(), lat);
    n_ops = op_is_read.size();
    applyStimulus(1'b0, 16'h5000, '0, lat);
    checkOutput("miss_read_first", 128'((op_is_read.size() > n_ops) ? op_is_read[n_ops] : 1'b0), 128'(1));
    checkOutput("miss_resp_after_l2", 128'(last_resp_cyc - last_read_resp_cyc), 128'(1));
    checkOutput("miss_data", up_rdata, default_line(12'h500));
    wait_drained();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 150; i++) begin
      t = 12'h100 + 12'($urandom_range(0, 5));
      applyStimulus(1'($urandom_range(0, 1)), {t, 4'($urandom)}, rand_line(), lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drained();

    $display("[TB] reset during a drain");
    wr = l2_write_count;
    l2_stall = 1'b1;
    applyStimulus(1'b1, 16'h7000, rand_line(), lat);
    n = 0;
    while (!l2_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_drain_started", 128'(l2_write), 128'(1));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_l2_write", 128'(l2_write), 128'(0));
    checkOutput("rst_up_resp", 128'(up_resp), 128'(0));
    checkOutput("rst_up_rdata", up_rdata, 128'(0));
    checkOutput("rst_l2_address", 128'(l2_address), 128'(0));
    checkOutput("rst_l2_wdata", l2_wdata, 128'(0));
    checkOutput("rst_l2_read", 128'(l2_read), 128'(0));
    buf_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    l2_stall = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("rst_no_late_write", 128'(l2_write_count - wr), 128'(0));
    applyStimulus(1'b0, 16'h7000, '0, lat);
    checkOutput("rst_buffer_cleared", up_rdata, default_line(12'h700));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_write_buffer.md
# l2_write_buffer

- Posted write buffer between the cache arbiter output and the L2 cache.
- Acknowledges L1 cacheline writebacks as soon as they are stored, then drains them to L2 when no upstream request is pending.
- Reads that miss the buffer pass straight through to L2. Reads that hit a buffered line are answered from the buffer.
- Removes L2 write latency from the L1 miss path.

## Interface
Parameters:
- DEPTH, 4, number of cacheline entries; power of two, 2..8.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- up_address  in  16 (lc3b_word)  request address from the arbiter.
- up_wdata  in  128 (lc3b_cacheline)  writeback data.
- up_read  in  1  read request, held until up_resp.
- up_write  in  1  write request, held until up_resp.
- up_resp  out  1  one-cycle completion pulse.
- up_rdata  out  128  read data, valid while up_resp=1.
- l2_address  out  16  address to L2.
- l2_wdata  out  128  write data to L2.
- l2_read  out  1  held until l2_resp.
- l2_write  out  1  held until l2_resp.
- l2_resp  in  1  one-cycle L2 completion pulse.
- l2_rdata  in  128  L2 read data, valid with l2_resp.

## Operation
- Storage is a circular FIFO of DEPTH entries. Each entry holds a valid bit, tag = address[15:4], and data.
- Line match compares address[15:4] only; bits [3:0] are ignored.
- At most one valid entry exists per tag.
- States: IDLE, WRITE, READ_L2, DRAIN, RESP.
- IDLE, priority order:
  - up_write with a tag match: overwrite that entry's data in place (coalesce), go to RESP.
  - up_write, no match, not full: push at the tail, go to RESP.
  - up_write, no match, full: go to DRAIN (forced drain). The write stays pending and is retried in IDLE.
  - up_read with a match: latch that entry's data into up_rdata, go to RESP.
  - up_read, no match: go to READ_L2.
  - No request and count>0: go to DRAIN.
  - Otherwise stay in IDLE.
- READ_L2: l2_read=1 with l2_address=up_address. On l2_resp, capture l2_rdata into up_rdata and go to RESP.
- DRAIN: l2_write=1 with the head entry's tag (low 4 bits zero) and data. On l2_resp, pop the head and go to IDLE. The drain is never abandoned once started.
- RESP: up_resp=1 for exactly one cycle, then IDLE. Requests are sampled only in IDLE, so a held request is never double-accepted.
- A read never bypasses a buffered write to the same line. Reads to other lines may go to L2 ahead of pending drains.
- Counter widths: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH).
  - empty = (count==0).
- WRITE is a one-cycle internal state reserved for the storage write-enable. The push happens on the IDLE→RESP edge; the WRITE state is optional and adds no latency if merged.

## Timing
- Reset values: state=IDLE, count=0, pointers=0, all valid=0; every output is 0, including up_rdata, l2_address and l2_wdata.
- Reset mid-operation clears all buffered data immediately (writes are lost) and deasserts l2_read/l2_write asynchronously.
- Write accept: request seen in IDLE at cycle t; up_resp at t+1.
- Read hit: same latency, up_resp at t+1.
- Read miss: l2_read from t+1 until l2_resp at cycle u; up_resp at u+1.
- Write when full: waits for one complete drain, then IDLE, then accept.
- All outputs are registered or decoded from state only; there is no combinational path from up_* or l2_* inputs to outputs.
- up_read and up_write never assert together; if they do, up_write wins.

## Configuration
- WBUF_READ_FWD_EN defined: read hits are served from the buffer as described above.
- Undefined: a read whose tag matches any entry goes to DRAIN repeatedly until no entry matches, then issues READ_L2. No read is ever answered from the buffer.

## Structure
- lc3b_types package adds:
  - lc3b_wbuf_state enum (IDLE, WRITE, READ_L2, DRAIN, RESP).
  - lc3b_line_tag typedef (12 bits).
  - Constant LC3B_LINE_OFFSET_BITS = 4.
- Sub-module wbuf_storage contains the entry array, valid bits, head/tail pointers, count, the tag-match vector and match index.
- The top level contains the FSM and the output registers.

## Test plan
- Single write 0x1230, data A → up_resp one cycle later. With no further requests, l2_write with l2_address 0x1230 and data A. Count returns to 0 after l2_resp.
- Write 0x2000 (A), then write 0x2008 (B) before draining → coalesced into one entry. Exactly one L2 write of B to 0x2000.
- Fill 4 entries (0x0000, 0x0010, 0x0020, 0x0030) with L2 stalled, then write 0x0040 → no up_resp until the 0x0000 drain completes. The 0x0040 entry lands in slot 0 (wrap).
- Buffer 0x4000=C, then read 0x4004 → up_rdata=C at t+1 with no L2 read. With the macro undefined: drain first, then L2 read.
- Read 0x5000 (no match) with 2 entries pending → l2_read issued before any drain. up_resp follows l2_resp by one cycle.
- Assert reset mid-DRAIN → l2_write drops in the same cycle. All outputs are 0 and count is 0. No later L2 write is issued.
